reg_rename: RTL and testbench

//  Register rename stage between decode and reg_file. Maps 32 architectural

---
 rtl/reg_rename_if.sv | 44 ++++
 rtl/reg_rename.sv | 152 +++++++++++++++
 tb/tb_reg_rename.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_rename_if.sv
// Rename-stage port bundle: decode request, renamed slot, writeback and free.
// The master side is the decode/commit environment, the slave side is reg_rename.
interface reg_rename_if #(
    parameter int AREG_W = 5,
    parameter int PHYS_W = 6
);
    // decode request
    logic              i_valid;
    logic              i_uses_rs;
    logic              i_uses_rt;
    logic              i_uses_rw;
    logic [AREG_W-1:0] i_rs;
    logic [AREG_W-1:0] i_rt;
    logic [AREG_W-1:0] i_rw;
    logic              o_ready;
    // renamed output slot
    logic              o_valid;
    logic              i_ready;
    logic [PHYS_W-1:0] o_rs_phys;
    logic [PHYS_W-1:0] o_rt_phys;
    logic [PHYS_W-1:0] o_rw_phys;
    logic [PHYS_W-1:0] o_old_rw_phys;
    logic              o_rs_busy;
    logic              o_rt_busy;
    // writeback and commit-free
    logic              i_wb_valid;
    logic [PHYS_W-1:0] i_wb_phys;
    logic              i_free_valid;
    logic [PHYS_W-1:0] i_free_phys;

    modport master (
        output i_valid, i_uses_rs, i_uses_rt, i_uses_rw, i_rs, i_rt, i_rw,
        output i_ready, i_wb_valid, i_wb_phys, i_free_valid, i_free_phys,
        input  o_ready, o_valid, o_rs_phys, o_rt_phys, o_rw_phys, o_old_rw_phys,
        input  o_rs_busy, o_rt_busy
    );

    modport slave (
        input  i_valid, i_uses_rs, i_uses_rt, i_uses_rw, i_rs, i_rt, i_rw,
        input  i_ready, i_wb_valid, i_wb_phys, i_free_valid, i_free_phys,
        output o_ready, o_valid, o_rs_phys, o_rt_phys, o_rw_phys, o_old_rw_phys,
        output o_rs_busy, o_rt_busy
    );
endinterface

// File: rtl/reg_rename.sv
// Register rename stage: map table, circular free list of physical tags,
// per-tag busy bits and a single registered output slot.
// The free list holds PHYS_REGS-ARCH_REGS entries; pointers wrap naturally,
// so that difference must be a power of two.
module reg_rename #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64,
    parameter int PHYS_W    = 6
) (
    input logic          clk,
    input logic          rst_n,
    reg_rename_if.slave  bus
);
    localparam int FREE_N = PHYS_REGS - ARCH_REGS;
    localparam int FPTR_W = $clog2(FREE_N);
    localparam int CNT_W  = FPTR_W + 1;

    // rename state
    logic [PHYS_W-1:0]    map_q [ARCH_REGS];
    logic [PHYS_W-1:0]    map_d [ARCH_REGS];
    logic [PHYS_W-1:0]    fl_q  [FREE_N];
    logic [PHYS_W-1:0]    fl_d  [FREE_N];
    logic [FPTR_W-1:0]    head_q, head_d;
    logic [FPTR_W-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [PHYS_REGS-1:0] busy_q, busy_d;

    // output slot
    logic              vld_q, vld_d;
    logic [PHYS_W-1:0] rs_q, rs_d;
    logic [PHYS_W-1:0] rt_q, rt_d;
    logic [PHYS_W-1:0] rw_q, rw_d;
    logic [PHYS_W-1:0] old_q, old_d;
    logic              rs_busy_q, rs_busy_d;
    logic              rt_busy_q, rt_busy_d;

    logic              alloc, fl_empty, fl_full, ready, accept, pop, free_req, push;
    logic [PHYS_W-1:0] rs_tag, rt_tag, new_tag, old_tag;
    logic              rs_busy, rt_busy;

    // handshake and source lookup against the pre-rename map
    always_comb begin
        alloc    = bus.i_uses_rw && (bus.i_rw != '0);
        fl_empty = (cnt_q == '0);
        fl_full  = (cnt_q == CNT_W'(FREE_N));
        ready    = (!vld_q || bus.i_ready) && (!alloc || !fl_empty);
        accept   = bus.i_valid && ready;
        pop      = accept && alloc;
        free_req = bus.i_free_valid && (bus.i_free_phys != '0);
        push     = free_req && !fl_full;
        rs_tag   = bus.i_uses_rs ? map_q[bus.i_rs] : '0;
        rt_tag   = bus.i_uses_rt ? map_q[bus.i_rt] : '0;
        new_tag  = fl_q[head_q];
        old_tag  = map_q[bus.i_rw];
        // a writeback landing in the accept cycle bypasses the busy bit
        rs_busy  = (rs_tag != '0) && busy_q[rs_tag] &&
                   !(bus.i_wb_valid && bus.i_wb_phys == rs_tag);
        rt_busy  = (rt_tag != '0) && busy_q[rt_tag] &&
                   !(bus.i_wb_valid && bus.i_wb_phys == rt_tag);
    end

    // map table, free list and busy-bit next state
    always_comb begin
        map_d  = map_q;
        fl_d   = fl_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (pop) begin
            head_d          = head_q + 1'b1;
            map_d[bus.i_rw] = new_tag;
        end
        // pop reads fl_q, so an entry pushed this cycle is never handed out
        if (push) begin
            fl_d[tail_q] = bus.i_free_phys;
            tail_d       = tail_q + 1'b1;
        end
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (pop && !push) cnt_d = cnt_q - 1'b1;
        // clear first so a same-tag allocation wins
        if (bus.i_wb_valid) busy_d[bus.i_wb_phys] = 1'b0;
        if (pop)            busy_d[new_tag]       = 1'b1;
    end

    // output slot: load on accept, drop when consumed, otherwise hold
    always_comb begin
        vld_d     = vld_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rw_d      = rw_q;
        old_d     = old_q;
        rs_busy_d = rs_busy_q;
        rt_busy_d = rt_busy_q;
        if (accept) begin
            vld_d     = 1'b1;
            rs_d      = rs_tag;
            rt_d      = rt_tag;
            rw_d      = alloc ? new_tag : '0;
            old_d     = alloc ? old_tag : '0;
            rs_busy_d = rs_busy;
            rt_busy_d = rt_busy;
        end else if (bus.i_ready) begin
            vld_d = 1'b0;
        end
    end

    // state registers; reset restores identity map and full free list
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= PHYS_W'(i);
            for (int i = 0; i < FREE_N; i++)    fl_q[i]  <= PHYS_W'(ARCH_REGS + i);
            head_q    <= '0;
            tail_q    <= '0;
            cnt_q     <= CNT_W'(FREE_N);
            busy_q    <= '0;
            vld_q     <= 1'b0;
            rs_q      <= '0;
            rt_q      <= '0;
            rw_q      <= '0;
            old_q     <= '0;
            rs_busy_q <= 1'b0;
            rt_busy_q <= 1'b0;
        end else begin
            map_q     <= map_d;
            fl_q      <= fl_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            vld_q     <= vld_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rw_q      <= rw_d;
            old_q     <= old_d;
            rs_busy_q <= rs_busy_d;
            rt_busy_q <= rt_busy_d;
        end
    end

    assign bus.o_ready       = ready;
    assign bus.o_valid       = vld_q;
    assign bus.o_rs_phys     = rs_q;
    assign bus.o_rt_phys     = rt_q;
    assign bus.o_rw_phys     = rw_q;
    assign bus.o_old_rw_phys = old_q;
    assign bus.o_rs_busy     = rs_busy_q;
    assign bus.o_rt_busy     = rt_busy_q;

    // returning a tag to an already full free list is a commit-side bug
    a_no_overfree: assert property (@(posedge clk) disable iff (!rst_n) !(free_req && fl_full));
endmodule

// File: tb/tb_reg_rename.sv
// Bench for reg_rename: directed scenarios plus random traffic against a
// queue-based reference model of the rename rules.
module tb_reg_rename;
    logic clk;
    logic rst_n;
    reg_rename_if #(.AREG_W(5), .PHYS_W(6)) rif ();

    reg_rename #(.ARCH_REGS(32), .PHYS_REGS(64), .PHYS_W(6)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (rif)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int unsigned n_vec;
    int unsigned n_err;

    // reference model
    int unsigned m_map [32];
    int unsigned m_fl [$];
    int unsigned m_pend [$];
    bit          m_busy [64];
    bit          m_vld;
    int unsigned m_rs, m_rt, m_rw, m_old;
    bit          m_rsb, m_rtb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < 32; a++) m_map[a] = a;
        m_fl.delete();
        for (int t = 32; t < 64; t++) m_fl.push_back(t);
        m_pend.delete();
        for (int t = 0; t < 64; t++) m_busy[t] = 0;
        m_vld = 0;
        m_rs = 0; m_rt = 0; m_rw = 0; m_old = 0; m_rsb = 0; m_rtb = 0;
    endtask

    task automatic set_idle();
        rif.i_valid = 0; rif.i_uses_rs = 0; rif.i_uses_rt = 0; rif.i_uses_rw = 0;
        rif.i_rs = 0; rif.i_rt = 0; rif.i_rw = 0; rif.i_ready = 1;
        rif.i_wb_valid = 0; rif.i_wb_phys = 0; rif.i_free_valid = 0; rif.i_free_phys = 0;
    endtask

    task automatic ren(input bit us, input bit ut, input bit uw,
                       input int rs, input int rt, input int rw);
        rif.i_valid = 1; rif.i_uses_rs = us; rif.i_uses_rt = ut; rif.i_uses_rw = uw;
        rif.i_rs = 5'(rs); rif.i_rt = 5'(rt); rif.i_rw = 5'(rw);
        rif.i_wb_valid = 0; rif.i_wb_phys = 0; rif.i_free_valid = 0; rif.i_free_phys = 0;
    endtask

    // async reset mid-cycle; outputs must clear before any clock edge
    task automatic do_reset();
        set_idle();
        rst_n = 0;
        #1;
        model_reset();
        chk("rst_o_valid", rif.o_valid, 0);
        chk("rst_rs", rif.o_rs_phys, 0);
        chk("rst_rt", rif.o_rt_phys, 0);
        chk("rst_rw", rif.o_rw_phys, 0);
        chk("rst_old", rif.o_old_rw_phys, 0);
        chk("rst_busy", {rif.o_rs_busy, rif.o_rt_busy}, 0);
        #2 rst_n = 1;
        @(posedge clk); #1;
    endtask

    // one clock: check o_ready, advance the model, check the slot
    task automatic step();
        bit          alloc, ready, acc, push_ok;
        int unsigned rs_t, rt_t, nt, old;
        #2;
        alloc = rif.i_uses_rw && rif.i_rw != 0;
        ready = (!m_vld || rif.i_ready) && (!alloc || m_fl.size() != 0);
        chk("o_ready", rif.o_ready, ready);
        acc     = rif.i_valid && ready;
        push_ok = rif.i_free_valid && rif.i_free_phys != 0 && m_fl.size() < 32;
        if (acc) begin
            rs_t  = rif.i_uses_rs ? m_map[rif.i_rs] : 0;
            rt_t  = rif.i_uses_rt ? m_map[rif.i_rt] : 0;
            m_rs  = rs_t;
            m_rt  = rt_t;
            m_rsb = rs_t != 0 && m_busy[rs_t] && !(rif.i_wb_valid && rif.i_wb_phys == rs_t);
            m_rtb = rt_t != 0 && m_busy[rt_t] && !(rif.i_wb_valid && rif.i_wb_phys == rt_t);
            m_rw  = 0;
            m_old = 0;
        end
        if (rif.i_wb_valid) m_busy[rif.i_wb_phys] = 0;
        if (acc && alloc) begin
            nt = m_fl.pop_front();
            old = m_map[rif.i_rw];
            m_map[rif.i_rw] = nt;
            m_busy[nt] = 1;
            m_rw = nt;
            m_old = old;
            m_pend.push_back(old);
        end
        if (push_ok) m_fl.push_back(rif.i_free_phys);
        if (acc) m_vld = 1;
        else if (rif.i_ready) m_vld = 0;
        @(posedge clk); #1;
        chk("o_valid", rif.o_valid, m_vld);
        if (m_vld) begin
            chk("o_rs_phys", rif.o_rs_phys, m_rs);
            chk("o_rt_phys", rif.o_rt_phys, m_rt);
            chk("o_rw_phys", rif.o_rw_phys, m_rw);
            chk("o_old_rw_phys", rif.o_old_rw_phys, m_old);
            chk("o_rs_busy", rif.o_rs_busy, m_rsb);
            chk("o_rt_busy", rif.o_rt_busy, m_rtb);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1;
        set_idle();
        #1;
        do_reset();

        // plain source lookup
        ren(1, 1, 0, 5, 7, 0); step();
        chk("d_rs5", rif.o_rs_phys, 5);
        chk("d_rt7", rif.o_rt_phys, 7);
        chk("d_rw_none", rif.o_rw_phys, 0);
        // two writes to r1, then a reader
        ren(0, 0, 1, 0, 0, 1); step();
        chk("d_rw1a", rif.o_rw_phys, 32);
        chk("d_old1a", rif.o_old_rw_phys, 1);
        ren(0, 0, 1, 0, 0, 1); step();
        chk("d_rw1b", rif.o_rw_phys, 33);
        chk("d_old1b", rif.o_old_rw_phys, 32);
        ren(1, 0, 0, 1, 0, 0); step();
        chk("d_rs33", rif.o_rs_phys, 33);
        chk("d_rs33_busy", rif.o_rs_busy, 1);

        // drain the free list
        do_reset();
        repeat (32) begin ren(0, 0, 1, 0, 0, 2); step(); end
        chk("d_last_tag", rif.o_rw_phys, 63);
        ren(0, 0, 1, 0, 0, 2);
        rif.i_free_valid = 1; rif.i_free_phys = 5;
        #1 chk("d_empty_stall", rif.o_ready, 0);
        step();
        ren(0, 0, 1, 0, 0, 2);
        #1 chk("d_refill_ready", rif.o_ready, 1);
        step();
        chk("d_reuse5", rif.o_rw_phys, 5);
        chk("d_reuse_old", rif.o_old_rw_phys, 63);

        // writeback bypass, r0 writes
        do_reset();
        ren(0, 0, 1, 0, 0, 3); step();
        chk("d_rw3", rif.o_rw_phys, 32);
        ren(1, 0, 0, 3, 0, 0);
        rif.i_wb_valid = 1; rif.i_wb_phys = 32;
        step();
        chk("d_bypass", rif.o_rs_busy, 0);
        ren(1, 0, 0, 3, 0, 0); step();
        chk("d_after_wb", rif.o_rs_busy, 0);
        ren(0, 0, 1, 0, 0, 0); step();
        chk("d_r0_rw", rif.o_rw_phys, 0);
        ren(0, 0, 1, 0, 0, 4); step();
        chk("d_r0_nopop", rif.o_rw_phys, 33);

        // backpressure hold
        ren(0, 0, 1, 0, 0, 6); step();
        ren(0, 0, 1, 0, 0, 7);
        rif.i_ready = 0;
        repeat (3) step();
        chk("d_hold_rw", rif.o_rw_phys, 34);
        rif.i_ready = 1; step();
        chk("d_release", rif.o_rw_phys, 35);
        ren(0, 0, 1, 0, 0, 8); step();
        chk("d_resume", rif.o_rw_phys, 36);

        // reset with a live slot
        do_reset();
        ren(0, 0, 1, 0, 0, 1); step();
        chk("d_post_rst", rif.o_rw_phys, 32);

        // random traffic; frees only return displaced tags
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            ren($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
            rif.i_valid = ($urandom_range(0, 3) != 0);
            rif.i_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                rif.i_wb_valid = 1;
                rif.i_wb_phys  = 6'($urandom_range(0, 63));
            end
            if (m_pend.size() > 0 && $urandom_range(0, 2) == 0) begin
                rif.i_free_valid = 1;
                rif.i_free_phys  = 6'(m_pend.pop_front());
            end
            step();
        end

        set_idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
